// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes for the execute-stage ALU and the
// state type of the multi-cycle multiply sequencer that borrows it.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_UNDEF = 4'b1111;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_ITER = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that reuses the shared ALU for its additions.
// Produces the low WIDTH bits of op_a * op_b; terminates early once the
// remaining multiplier bits are all zero.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    seq_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             iter_last;

    // Final iteration: no multiplier bits left after this shift, or all WIDTH bits consumed
    assign iter_last = ((mplier >> 1) == '0) || (cnt == LAST_CNT);

    // Sequencer FSM with datapath registers and registered busy/done flags.
    // The result register takes alu_result on the edge entering DONE, which is
    // the same value acc takes on that edge, so result is valid while done=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SEQ_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        cnt    <= '0;
                        if (op_b == '0) begin
                            state  <= SEQ_DONE;
                            result <= '0;
                            done   <= 1'b1;
                        end else begin
                            state <= SEQ_ITER;
                            busy  <= 1'b1;
                        end
                    end
                end
                SEQ_ITER: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (iter_last) begin
                        state  <= SEQ_DONE;
                        result <= alu_result;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    state <= SEQ_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // ALU operand/control drive: ADD of acc and the gated multiplicand while iterating
    always_comb begin
        alu_ctrl = ALU_AND;
        alu_a    = '0;
        alu_b    = '0;
        if (state == SEQ_ITER) begin
            alu_ctrl = ALU_ADD;
            alu_a    = acc;
            alu_b    = mplier[0] ? mcand : '0;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: directed vector table, hand
// sequences for reset / ignored start, and randomized operands against a
// plain-arithmetic multiply model with an external ALU model.
module tb_alu_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] alub_trace [0:63];

    alu_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_result (alu_result),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared combinational ALU
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0011: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Issue one multiply, follow it until done (bounded), check the busy
    // profile and the ALU control rule every cycle. extra_at>0 pulses a second
    // start that many cycles after acceptance.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int extra_at, output int lat, output logic [W-1:0] res);
        int  k;
        bit  ctrl_bad;
        bit  busy_bad;
        k = 0;
        for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
        ctrl_bad = 0;
        busy_bad = 0;
        lat = -1;
        res = 'x;
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        for (int n = 1; n <= W + 6; n++) begin
            @(negedge clk);
            start = (n == extra_at);
            if (n == extra_at) begin
                op_a = $urandom;
                op_b = $urandom | 32'h1;
            end
            alub_trace[n] = alu_b;
            if (alu_ctrl !== (busy ? 4'b0010 : 4'b0000)) ctrl_bad = 1;
            if (busy !== (n <= k)) busy_bad = 1;
            if (done === 1'b1) begin
                lat = n;
                res = result;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) $display("FAIL %s timeout: no done within %0d cycles", tag, W + 6);
        check({tag, " latency"}, lat, k + 1);
        check({tag, " result"}, res, a * b);
        check({tag, " ctrl_rule"}, {31'd0, ctrl_bad}, 32'd0);
        check({tag, " busy_profile"}, {31'd0, busy_bad}, 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        int           exp_lat;
    } vec_t;

    initial begin
        vec_t         vecs [7];
        int           lat;
        logic [W-1:0] res;
        int           extra_dones;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{32'd7,        32'd6,        32'd42,         4};
        vecs[1] = '{32'h12345678, 32'd0,        32'd0,          1};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  33};
        vecs[3] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,   4};
        vecs[4] = '{32'd3,        32'd3,        32'd9,          3};
        vecs[5] = '{32'd1,        32'h80000000, 32'h80000000,  33};
        vecs[6] = '{32'h10,       32'd1,        32'h10,         2};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 0, lat, res);
            check($sformatf("vec%0d table_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d table_result", i), res, vecs[i].exp_res);
            if (i == 0) begin
                check("7x6 alu_b iter1", alub_trace[1], 32'd0);
                check("7x6 alu_b iter2", alub_trace[2], 32'd14);
            end
        end

        // Second start during ITER is ignored; exactly one done
        run_op("ignored_start", 32'hFFFFFFFD, 32'd5, 2, lat, res);
        check("ignored_start result", res, 32'hFFFFFFF1);
        extra_dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_dones++;
        end
        check("ignored_start no_second_op", extra_dones, 0);
        check("ignored_start result_held", result, 32'hFFFFFFF1);

        // Asynchronous reset in the middle of ITER
        @(negedge clk);
        start = 1'b1;
        op_a  = 32'hFFFFFFFF;
        op_b  = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset busy", {31'd0, busy}, 32'd0);
        check("async_reset done", {31'd0, done}, 32'd0);
        check("async_reset alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("async_reset alu_a", alu_a, 32'd0);
        check("async_reset alu_b", alu_b, 32'd0);
        check("async_reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset", 32'd3, 32'd3, 0, lat, res);
        check("post_reset result9", res, 32'd9);

        // Randomized operands with random idle gaps
        for (int t = 0; t < 200; t++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) rb = '0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op($sformatf("rnd%0d", t), ra, rb, 0, lat, res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
